// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
package data_mem_arbiter_pkg;

   localparam int unsigned DATA_WIDTH       = 32;
   localparam int unsigned NUM_DMEM_MASTERS = 2;

   // Requester identifier: 0 = load-store unit, 1 = debug/DMA master.
   typedef logic [0:0] dmem_id_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side and memory-side req/gnt/rvalid signals of the data-memory arbiter.
interface data_mem_arbiter_if
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned DW = DATA_WIDTH
);

   logic [NUM_DMEM_MASTERS-1:0]         req_i;
   logic [NUM_DMEM_MASTERS-1:0]         gnt_o;
   logic [NUM_DMEM_MASTERS-1:0]         rvalid_o;
   logic [NUM_DMEM_MASTERS-1:0][DW-1:0] addr_i;
   logic [NUM_DMEM_MASTERS-1:0]         we_i;
   logic [NUM_DMEM_MASTERS-1:0][DW-1:0] wdata_i;
   logic [DW-1:0]                       rdata_o;

   logic                                data_req_o;
   logic                                data_gnt_i;
   logic                                data_rvalid_i;
   logic [DW-1:0]                       data_addr_o;
   logic                                data_we_o;
   logic [DW-1:0]                       data_wdata_o;
   logic [DW-1:0]                       data_rdata_i;
   logic                                err_o;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, data_gnt_i, data_rvalid_i, data_rdata_i,
      output gnt_o, rvalid_o, rdata_o, data_req_o, data_addr_o, data_we_o,
             data_wdata_o, err_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, data_gnt_i, data_rvalid_i, data_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, data_req_o, data_addr_o, data_we_o,
             data_wdata_o, err_o
   );

endinterface

// File: rtl/data_mem_arbiter_resp_id_fifo.sv
// In-order FIFO of requester ids for granted transactions awaiting rvalid.
module resp_id_fifo
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  dmem_id_t push_data_i,
   input  logic     pop_i,
   output dmem_id_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dmem_id_t         mem_q [DEPTH];
   dmem_id_t         mem_d [DEPTH];
   logic             push_ok, pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the LSU (port 0) and
// the debug/DMA master (port 1); responses are routed back in issue order.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input logic              clk_i,
   input logic              rst_ni,
   data_mem_arbiter_if.slave bus
);

   dmem_id_t sel_c;
   dmem_id_t head_c;
   dmem_id_t last_q, last_d;
   dmem_id_t lock_sel_q, lock_sel_d;
   logic     lock_q, lock_d;
   logic     full_c, empty_c;
   logic     req_c, hs_c, pop_c;

   // A stalled request keeps its port until granted; otherwise alternate on contest.
   always_comb begin
      sel_c = dmem_id_t'(0);
      if (lock_q) begin
         sel_c = lock_sel_q;
      end else if (bus.req_i == 2'b10) begin
         sel_c = dmem_id_t'(1);
      end else if (bus.req_i == 2'b11) begin
         sel_c = ~last_q;
      end
   end

   assign req_c = rst_ni & (bus.req_i[sel_c] | lock_q) & ~full_c;
   assign hs_c  = req_c & bus.data_gnt_i;
   assign pop_c = rst_ni & bus.data_rvalid_i & ~empty_c;

   // Every output is forced low while reset is held.
   always_comb begin
      bus.gnt_o           = '0;
      bus.gnt_o[sel_c]    = hs_c;
      bus.rvalid_o        = '0;
      bus.rvalid_o[head_c] = pop_c;
      bus.data_req_o      = req_c;
      bus.data_addr_o     = rst_ni ? bus.addr_i[sel_c]  : '0;
      bus.data_we_o       = rst_ni & bus.we_i[sel_c];
      bus.data_wdata_o    = rst_ni ? bus.wdata_i[sel_c] : '0;
      bus.rdata_o         = rst_ni ? bus.data_rdata_i   : '0;
      bus.err_o           = rst_ni & bus.data_rvalid_i & empty_c;
   end

   always_comb begin
      last_d     = last_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      if (hs_c) begin
         last_d = sel_c;
         lock_d = 1'b0;
      end else if (req_c) begin
         lock_d     = 1'b1;
         lock_sel_d = sel_c;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q     <= dmem_id_t'(1);
         lock_q     <= 1'b0;
         lock_sel_q <= dmem_id_t'(0);
      end else begin
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   resp_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_id_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (hs_c),
      .push_data_i (sel_c),
      .pop_i       (pop_c),
      .head_o      (head_c),
      .full_o      (full_c),
      .empty_o     (empty_c)
   );

endmodule
